// File: rtl/hzrd_ctrl_pkg.sv
// Shared pipeline definitions: memory-FSM states, result-select and
// forwarding-select encodings, and the forwarding comparator.
package pipe_pkg;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WAIT = 2'd1,
        M_ERR  = 2'd2
    } mstate_t;

    localparam logic [1:0] RSLT_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Forward select for one EX source register; M beats W, x0 never forwards
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rdm,
        input logic       regWrtm,
        input logic [4:0] rdw,
        input logic       regWrtw
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (regWrtm && (rdm != 5'd0) && (rdm == rs)) begin
            sel = FWD_M;
        end else if (regWrtw && (rdw != 5'd0) && (rdw == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hzrd_ctrl_fwd.sv
// EX-stage forwarding selects. Purely combinational; one instance serves
// both ALU operands by calling the shared comparator twice.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] i_rs1e,
    input  logic [4:0] i_rs2e,
    input  logic [4:0] i_rdm,
    input  logic       i_regWrtm,
    input  logic [4:0] i_rdw,
    input  logic       i_regWrtw,
    output logic [1:0] o_fwdAe,
    output logic [1:0] o_fwdBe
);

    // Same comparator applied to operand A and operand B
    always_comb begin
        o_fwdAe = fwd_sel(i_rs1e, i_rdm, i_regWrtm, i_rdw, i_regWrtw);
        o_fwdBe = fwd_sel(i_rs2e, i_rdm, i_regWrtm, i_rdw, i_regWrtw);
    end

endmodule

// File: rtl/hzrd_ctrl.sv
// Hazard / stall controller for the 5-stage pipeline: forwarding selects,
// load-use and branch handling, and the M-stage memory wait FSM with timeout.
// Optional build macro HZRD_PERF_EN adds saturating 32-bit event counters.
// dbgMstate exposes the memory FSM state for observation.
module hzrd_ctrl
    import pipe_pkg::*;
#(
    parameter int TMO  = 16,
    parameter int CNTW = 5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] rs1d,
    input  logic [4:0] rs2d,
    input  logic [4:0] rs1e,
    input  logic [4:0] rs2e,
    input  logic [4:0] rde,
    input  logic [1:0] rsltSrce,
    input  logic       pcSrce,
    input  logic [4:0] rdm,
    input  logic       regWrtm,
    input  logic       memReqm,
    input  logic       dmemAck,
    input  logic [4:0] rdw,
    input  logic       regWrtw,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushW,
    output logic [1:0] fwdAe,
    output logic [1:0] fwdBe,
    output logic       memErr,
    output mstate_t    dbgMstate
`ifdef HZRD_PERF_EN
    ,
    output logic [31:0] lwStallCnt,
    output logic [31:0] memStallCnt,
    output logic [31:0] flushCnt
`endif
);

    mstate_t         r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_memErr;
    logic [1:0]      w_fwdA;
    logic [1:0]      w_fwdB;
    logic            w_lwStall;
    logic            w_memStall;

    fwd_unit u_fwd (
        .i_rs1e    (rs1e),
        .i_rs2e    (rs2e),
        .i_rdm     (rdm),
        .i_regWrtm (regWrtm),
        .i_rdw     (rdw),
        .i_regWrtw (regWrtw),
        .o_fwdAe   (w_fwdA),
        .o_fwdBe   (w_fwdB)
    );

    // Load in E whose destination feeds the instruction in D
    assign w_lwStall = (rsltSrce == RSLT_LOAD) && (rde != 5'd0) &&
                       ((rde == rs1d) || (rde == rs2d));

    // An outstanding access, or a failed one, freezes the whole pipe
    assign w_memStall = (memReqm && !dmemAck && (r_state != M_ERR)) ||
                        (r_state == M_ERR);

    // Memory wait FSM: counts unacknowledged cycles, M_ERR is terminal
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= M_IDLE;
            r_cnt    <= '0;
            r_memErr <= 1'b0;
        end else begin
            case (r_state)
                M_IDLE: begin
                    if (memReqm && !dmemAck) begin
                        r_state <= M_WAIT;
                        r_cnt   <= CNTW'(1);
                    end
                end
                M_WAIT: begin
                    if (dmemAck) begin
                        r_state <= M_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNTW'(TMO - 1)) begin
                        r_state  <= M_ERR;
                        r_memErr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                M_ERR: begin
                    r_memErr <= 1'b1;
                end
                default: begin
                    r_state <= M_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Stall/flush steering; reset forces bubbles everywhere and no forwarding
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b1;
        flushE = 1'b1;
        flushW = 1'b1;
        fwdAe  = FWD_RF;
        fwdBe  = FWD_RF;
        if (rstn) begin
            fwdAe = w_fwdA;
            fwdBe = w_fwdB;
            if (w_memStall) begin
                // E is frozen, so branch/load-use decisions wait for release
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushD = 1'b0;
                flushE = 1'b0;
                flushW = 1'b1;
            end else begin
                stallF = w_lwStall;
                stallD = w_lwStall;
                flushD = pcSrce;
                flushE = w_lwStall || pcSrce;
                flushW = 1'b0;
            end
        end
    end

    assign memErr    = r_memErr;
    assign dbgMstate = r_state;

`ifdef HZRD_PERF_EN
    logic [31:0] r_lwCnt;
    logic [31:0] r_msCnt;
    logic [31:0] r_flCnt;

    // Saturating event counters for load-use, memory stall and branch flush
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lwCnt <= '0;
            r_msCnt <= '0;
            r_flCnt <= '0;
        end else begin
            if (w_lwStall && !w_memStall && (r_lwCnt != '1)) begin
                r_lwCnt <= r_lwCnt + 32'd1;
            end
            if (w_memStall && (r_msCnt != '1)) begin
                r_msCnt <= r_msCnt + 32'd1;
            end
            if (pcSrce && !w_memStall && (r_flCnt != '1)) begin
                r_flCnt <= r_flCnt + 32'd1;
            end
        end
    end

    assign lwStallCnt  = r_lwCnt;
    assign memStallCnt = r_msCnt;
    assign flushCnt    = r_flCnt;
`endif

endmodule

// File: tb/tb_hzrd_ctrl.sv
// Bench for hzrd_ctrl: directed and random stimulus, reference model of the
// hazard rules, expected-output queue drained by a mid-cycle monitor.
module tb_hzrd_ctrl;
    import pipe_pkg::*;

    localparam int TMO = 16;
`ifdef HZRD_PERF_EN
    localparam int W = 110;
`else
    localparam int W = 14;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsltSrce;
    logic       pcSrce, regWrtm, memReqm, dmemAck, regWrtw;
    logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr;
    logic [1:0] fwdAe, fwdBe;
    mstate_t    dbgMstate;
`ifdef HZRD_PERF_EN
    logic [31:0] lwStallCnt, memStallCnt, flushCnt;
`endif

    hzrd_ctrl #(.TMO(TMO), .CNTW(5)) dut (
        .clk(clk), .rstn(rstn),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
        .rsltSrce(rsltSrce), .pcSrce(pcSrce), .rdm(rdm), .regWrtm(regWrtm),
        .memReqm(memReqm), .dmemAck(dmemAck), .rdw(rdw), .regWrtw(regWrtw),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .fwdAe(fwdAe), .fwdBe(fwdBe), .memErr(memErr), .dbgMstate(dbgMstate)
`ifdef HZRD_PERF_EN
        , .lwStallCnt(lwStallCnt), .memStallCnt(memStallCnt), .flushCnt(flushCnt)
`endif
    );

    // ---------------- reference model ----------------
    bit          m_err;
    int          m_age;      // consecutive unacknowledged request cycles
    logic [31:0] m_lw, m_ms, m_fl;
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (regWrtm && rdm != 0 && rdm == rs) return 2'b10;
        if (regWrtw && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_lw();
        return (rsltSrce == 2'b01) && (rde != 0) && (rde == rs1d || rde == rs2d);
    endfunction

    function automatic bit ref_ms();
        return m_err || (memReqm && !dmemAck);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    task automatic model_reset();
        m_err = 0; m_age = 0; m_lw = 0; m_ms = 0; m_fl = 0;
    endtask

    // Wait for the next active edge and account for what the DUT saw there
    task automatic advance();
        bit ms, lw;
        @(posedge clk);
        #1;
        cyc++;
        if (rstn) begin
            ms = ref_ms();
            lw = ref_lw();
            if (lw && !ms) m_lw = sat_inc(m_lw);
            if (ms)        m_ms = sat_inc(m_ms);
            if (pcSrce && !ms) m_fl = sat_inc(m_fl);
            if (!m_err) begin
                if (memReqm && !dmemAck) begin
                    m_age++;
                    if (m_age >= TMO) m_err = 1;
                end else begin
                    m_age = 0;
                end
            end
        end
    endtask

    // Expected outputs for the inputs now applied
    task automatic push_expect();
        logic [13:0] c;
        logic [1:0]  st;
        bit ms, lw;
        if (!rstn) begin
            model_reset();
            c = {4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, 2'(M_IDLE)};
        end else begin
            ms = ref_ms();
            lw = ref_lw();
            st = m_err ? 2'(M_ERR) : (m_age > 0 ? 2'(M_WAIT) : 2'(M_IDLE));
            if (ms)
                c = {4'b1111, 1'b0, 1'b0, 1'b1, ref_fwd(rs1e), ref_fwd(rs2e), m_err, st};
            else
                c = {lw, lw, 2'b00, pcSrce, (lw | pcSrce), 1'b0,
                     ref_fwd(rs1e), ref_fwd(rs2e), m_err, st};
        end
`ifdef HZRD_PERF_EN
        exp_q.push_back({c, m_lw, m_ms, m_fl});
`else
        exp_q.push_back(c);
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        rsltSrce = 0; pcSrce = 0; regWrtm = 0; memReqm = 0; dmemAck = 0; regWrtw = 0;
    endtask

    task automatic rand_inputs();
        rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
        rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
        rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
        rdw  = 5'($urandom_range(0, 3));
        rsltSrce = 2'($urandom_range(0, 3));
        pcSrce   = ($urandom_range(0, 3) == 0);
        regWrtm  = 1'($urandom_range(0, 1));
        regWrtw  = 1'($urandom_range(0, 1));
        // an outstanding access keeps its request up until it completes
        memReqm  = (m_age > 0 && !m_err) ? 1'b1 : ($urandom_range(0, 2) == 0);
        dmemAck  = ($urandom_range(0, 3) == 0);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            advance(); rstn = 0; rand_inputs(); push_expect();
        end
        advance(); rstn = 1; clear_inputs(); push_expect();
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            advance();
            rstn = ($urandom_range(0, 59) != 0);
            rand_inputs();
            push_expect();
        end
        advance(); rstn = 1; clear_inputs(); push_expect();
    endtask

    task automatic mem_hold(input int n, input logic pc);
        for (int i = 0; i < n; i++) begin
            advance(); clear_inputs(); memReqm = 1; pcSrce = pc; push_expect();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] act, expv;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
`ifdef HZRD_PERF_EN
            act = {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                   fwdAe, fwdBe, memErr, 2'(dbgMstate), lwStallCnt, memStallCnt, flushCnt};
`else
            act = {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                   fwdAe, fwdBe, memErr, 2'(dbgMstate)};
`endif
            tests++;
            if (act !== expv) begin
                fails++;
                $display("FAIL outputs cycle %0d: got %h expected %h", cyc, act, expv);
            end
        end
    end

    // ---------------- stimulus sequence ----------------
    initial begin
        rstn = 0;
        clear_inputs();
        model_reset();
        reset_cycles(2);

        // forwarding
        advance(); clear_inputs(); regWrtm = 1; rdm = 5; rs1e = 5;
        regWrtw = 1; rdw = 5; rs2e = 5; push_expect();
        advance(); clear_inputs(); regWrtm = 1; rdm = 5; rs1e = 6;
        regWrtw = 1; rdw = 6; rs2e = 5; push_expect();
        advance(); clear_inputs(); regWrtm = 1; rdm = 0; rs1e = 0;
        regWrtw = 1; rdw = 0; rs2e = 0; push_expect();
        // load-use, then x0 destination
        advance(); clear_inputs(); rsltSrce = 2'b01; rde = 7; rs2d = 7; push_expect();
        advance(); clear_inputs(); rsltSrce = 2'b01; rde = 0; rs2d = 0; push_expect();
        // branch alone, branch with load-use
        advance(); clear_inputs(); pcSrce = 1; push_expect();
        advance(); clear_inputs(); pcSrce = 1; rsltSrce = 2'b01; rde = 3; rs1d = 3; push_expect();
        // three-cycle memory wait with a pending branch, then ack
        mem_hold(3, 1'b1);
        advance(); clear_inputs(); memReqm = 1; dmemAck = 1; pcSrce = 1; push_expect();
        advance(); clear_inputs(); push_expect();
        // single-cycle access
        advance(); clear_inputs(); memReqm = 1; dmemAck = 1; push_expect();

        random_phase(400);

        // timeout: memErr sticky, stalls persist even without a request
        reset_cycles(1);
        mem_hold(20, 1'b0);
        for (int i = 0; i < 4; i++) begin
            advance(); rand_inputs(); push_expect();
        end
        reset_cycles(2);

        // reset in the middle of a wait
        mem_hold(5, 1'b0);
        reset_cycles(2);

        random_phase(300);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: sequence did not finish by time %0t, expected under 200000", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
